ddr_read_bridge: RTL

//  Sits between the buffer-init controller and the AXI4 DDR port. Takes one read command
//  (ddr_addr/ddr_read_en/ddr_length), splits it into INCR bursts of at most max_burst_len beats,

---
 rtl/ddr_rd_pkg.sv | 20 ++
 rtl/ddr_rd_burst_calc.sv | 24 ++
 rtl/ddr_read_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR read bridge: FSM encoding, AXI burst type,
// and beat-size helpers derived from the data width.
package ddr_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         DDR_DATA_WIDTH = 512;
  localparam int         BYTES_PER_BEAT = DDR_DATA_WIDTH / 8;
  localparam logic [2:0] ARSIZE         = 3'($clog2(BYTES_PER_BEAT));

  function automatic logic [2:0] arsize_for(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/ddr_rd_burst_calc.sv
// Sizes the next AR burst from the beats still owed and computes the address
// that follows it. Purely combinational.
module ddr_rd_burst_calc #(
  parameter int          ddr_addr_width       = 32,
  parameter int          ddr_block_size_width = 8,
  parameter int unsigned max_burst_len        = 16,
  parameter int unsigned beat_shift           = 6
) (
  input  logic [ddr_block_size_width-1:0] remaining,
  input  logic [ddr_addr_width-1:0]       addr,
  output logic [8:0]                      beats,
  output logic [7:0]                      arlen,
  output logic [ddr_addr_width-1:0]       next_addr
);

  always_comb begin
    if (32'(remaining) < 32'(max_burst_len)) beats = 9'(remaining);
    else                                     beats = 9'(max_burst_len);
    arlen     = 8'(beats - 9'd1);
    // wraps naturally at the top of the address space
    next_addr = addr + (ddr_addr_width'(beats) << beat_shift);
  end

endmodule

// File: rtl/ddr_read_bridge.sv
// Splits one read command into AXI4 INCR bursts (one outstanding) and streams the
// returned beats out. Optional DDR_RD_ERR_EN adds a sticky rd_err status output.
module ddr_read_bridge
  import ddr_rd_pkg::*;
#(
  parameter int          ddr_addr_width       = 32,
  parameter int          ddr_data_width       = 512,
  parameter int          ddr_block_size_width = 8,
  parameter int unsigned max_burst_len        = 16
) (
  input  logic                            clk,
  input  logic                            n_reset,
  input  logic [ddr_addr_width-1:0]       ddr_addr,
  input  logic                            ddr_read_en,
  input  logic [ddr_block_size_width-1:0] ddr_length,
`ifdef DDR_RD_ERR_EN
  output logic                            rd_err,
`endif
  output logic [ddr_data_width-1:0]       ddr_data,
  output logic                            ddr_valid,
  output logic                            busy,
  output logic [ddr_addr_width-1:0]       m_araddr,
  output logic [7:0]                      m_arlen,
  output logic [2:0]                      m_arsize,
  output logic [1:0]                      m_arburst,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  input  logic [ddr_data_width-1:0]       m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rlast,
  input  logic                            m_rvalid,
  output logic                            m_rready
);

  localparam logic [2:0]                ARSIZE_W   = arsize_for(ddr_data_width);
  localparam int unsigned               BEAT_SHIFT = $clog2(ddr_data_width / 8);
  localparam logic [ddr_addr_width-1:0] ALIGN_MASK =
    ~((ddr_addr_width'(1) << BEAT_SHIFT) - ddr_addr_width'(1));

  rd_state_e                       state, nxt_state;
  logic [ddr_addr_width-1:0]       addr_q;
  logic [ddr_block_size_width-1:0] remaining;
  logic [8:0]                      beat_cnt;
  logic [8:0]                      burst_beats;
  logic [7:0]                      burst_len;
  logic [ddr_addr_width-1:0]       burst_next_addr;
  logic                            cmd_accept, ar_fire, r_fire, last_beat;

  ddr_rd_burst_calc #(
    .ddr_addr_width      (ddr_addr_width),
    .ddr_block_size_width(ddr_block_size_width),
    .max_burst_len       (max_burst_len),
    .beat_shift          (BEAT_SHIFT)
  ) u_calc (
    .remaining(remaining),
    .addr     (addr_q),
    .beats    (burst_beats),
    .arlen    (burst_len),
    .next_addr(burst_next_addr)
  );

  assign cmd_accept = (state == ST_IDLE) && ddr_read_en && (ddr_length != '0);
  assign ar_fire    = (state == ST_ADDR) && m_arvalid && m_arready;
  assign r_fire     = (state == ST_DATA) && m_rvalid && m_rready;
  // burst length is tracked internally; m_rlast never steers control
  assign last_beat  = (beat_cnt == {1'b0, m_arlen});
  assign m_arsize   = ARSIZE_W;
  assign m_arburst  = AXI_BURST_INCR;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      ST_IDLE: if (cmd_accept) nxt_state = ST_ADDR;
      ST_ADDR: if (ar_fire)    nxt_state = ST_DATA;
      ST_DATA: if (r_fire && last_beat)
                 nxt_state = (remaining == '0) ? ST_IDLE : ST_ADDR;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr_q    <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      ddr_data  <= '0;
      ddr_valid <= 1'b0;
    end else begin
      ddr_valid <= r_fire;
      if (r_fire) ddr_data <= m_rdata;
      case (state)
        ST_IDLE: if (cmd_accept) begin
          addr_q    <= ddr_addr & ALIGN_MASK;
          remaining <= ddr_length;
          busy      <= 1'b1;
        end
        ST_ADDR: begin
          // first ADDR cycle loads the AR fields; they then hold until accepted
          if (!m_arvalid) begin
            m_araddr  <= addr_q;
            m_arlen   <= burst_len;
            m_arvalid <= 1'b1;
          end else if (m_arready) begin
            m_arvalid <= 1'b0;
            remaining <= remaining - ddr_block_size_width'(burst_beats);
            addr_q    <= burst_next_addr;
            beat_cnt  <= '0;
            m_rready  <= 1'b1;
          end
        end
        ST_DATA: if (r_fire) begin
          beat_cnt <= beat_cnt + 9'd1;
          if (last_beat) begin
            m_rready <= 1'b0;
            if (remaining == '0) busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DDR_RD_ERR_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)        rd_err <= 1'b0;
    else if (cmd_accept) rd_err <= 1'b0;
    else if (r_fire && ((m_rresp != 2'b00) || (m_rlast != last_beat)))
      rd_err <= 1'b1;
  end
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{m_rresp, m_rlast};
`endif

endmodule
